seq_recognizer_param: RTL and testbench
=======================================

Name: seq_recognizer_param

Overview:
- Parametrised serial sequence recognizer; next generation of the fixed Mealy sequence recognizer.
- Detects a compile-time pattern of LEN bits (2..16) in a 1-bit serial stream sampled on qualified clock edges.
- Provides both a Mealy output (same cycle as the final bit) and a registered Moore-style output, with selectable overlapping or non-overlapping detection.
- Sits between the serial input source and downstream control logic.

Parameters:
- LEN, 4, pattern length in bits; legal range 2..16.
- PATTERN, 4'b1011, pattern value; PATTERN[LEN-1] is the first bit received, PATTERN[0] the last.
- OVERLAP, 1, 1 = a match may reuse trailing bits of the previous match; 0 = history restarts after each match.
- CNT_W, 8, match counter width (used only with the optional feature).

Ports:
- clk, input, 1, clock; rising edge active.
- rst, input, 1, asynchronous active-high reset.
- x, input, 1, serial data bit.
- x_valid, input, 1, qualifies x; when 0 the block holds all state.
- z, output, 1, Mealy match: high in the cycle the final pattern bit is presented.
- z_reg, output, 1, registered match: z delayed one clock, a one-cycle pulse.
- match_cnt, output, CNT_W, saturating match count (only with SEQ_MATCH_CNT_EN).

Behaviour:
- State:
  - hist[LEN-2:0] shift register; newest bit at hist[0].
  - fill counter, 0..LEN-1, giving the number of valid history bits.
- Reset (rst=1, asynchronous): hist=0, fill=0, z_reg=0, match_cnt=0. z is forced to 0 while rst=1.
- Match condition, combinational: cand = {hist, x}; hit = x_valid & (fill == LEN-1) & (cand == PATTERN).
- z = hit & ~rst. There is no latency from x to z.
- On a rising clk edge with x_valid=1:
  - hist <= {hist[LEN-3:0], x}; for LEN=2, hist <= x.
  - fill <= min(fill+1, LEN-1).
  - If hit and OVERLAP=0: hist <= 0 and fill <= 0. This overrides the normal update, so the next match needs LEN fresh bits.
- On a rising clk edge with x_valid=0: hist and fill hold, z=0, z_reg <= 0.
- z_reg <= hit on every rising edge. z_reg is high for exactly one cycle per match and is never stretched.
- No false matches during warm-up: fewer than LEN valid bits received since reset or a non-overlap restart never produces hit, even if the zero-filled hist would match.
- Overlap: back-to-back matches are possible every cycle, e.g. PATTERN=1111 with a continuous stream of 1s.
- Reset mid-stream discards partial history immediately, without waiting for a clock edge.
- Only the pattern-length state exists. Transitions are implicit in the shift/fill logic and no explicit KMP state table is required. An equivalent LEN-state FSM implementation is acceptable if its port behaviour is identical.

Optional Feature:
- Macro: SEQ_MATCH_CNT_EN.
- Defined:
  - match_cnt increments by 1 on each clock edge where hit=1.
  - It saturates at 2^CNT_W-1 and holds there.
  - It is cleared only by rst.
- Undefined: match_cnt port and counter logic are absent. All other behaviour is identical.

Test Plan:
- Defaults (PATTERN=1011, OVERLAP=1): reset, then x_valid=1 with stream 1,0,1,1,0,1,1 -> z high on bits 4 and 7; z_reg high the cycle after each; match_cnt=2.
- OVERLAP=0, same stream -> z high on bit 4 only; match_cnt=1.
- Warm-up: PATTERN=4'b0000, stream 0,0,0 after reset -> z stays 0; fourth 0 -> z=1.
- Gaps: stream 1,0 then x_valid=0 for 3 cycles, then 1,1 -> match on the last bit; z and z_reg are 0 during the gap cycles.
- Reset mid-stream: send 1,0,1, assert rst asynchronously between edges, release, send 1 -> no match; z_reg=0 and match_cnt=0 immediately on rst assertion.
- Saturation (CNT_W=2, PATTERN=2'b11, OVERLAP=1): eight consecutive 1s -> 7 hits; match_cnt reaches 3 and holds at 3.

Source files
------------

// File: rtl/seq_recognizer_param.sv
// Parametrised serial sequence recognizer with Mealy and registered match outputs.
// Optional saturating match counter enabled by defining SEQ_MATCH_CNT_EN.
module seq_recognizer_param #(
    parameter int             LEN     = 4,
    parameter logic [LEN-1:0] PATTERN = 4'b1011,
    parameter int             OVERLAP = 1,
    parameter int             CNT_W   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic x,
    input  logic x_valid,
    output logic z,
    output logic z_reg
`ifdef SEQ_MATCH_CNT_EN
    ,
    output logic [CNT_W-1:0] match_cnt
`endif
);

    localparam int FW = $clog2(LEN);
    localparam logic [FW-1:0] FULL = FW'(LEN - 1);

    // Reject illegal configurations at elaboration time.
    if (LEN < 2 || LEN > 16 || CNT_W < 1) begin : g_bad_cfg
        $error("seq_recognizer_param: illegal LEN or CNT_W");
    end

    logic [LEN-2:0] hist;
    logic [LEN-2:0] hist_next;
    logic [FW-1:0]  fill;
    logic [FW-1:0]  fill_next;
    logic [LEN-1:0] cand;
    logic           hit;

    // Candidate window is the stored history plus the bit on the wire.
    always_comb begin
        cand = {hist, x};
        hit  = x_valid && (fill == FULL) && (cand == PATTERN) && !rst;
        z    = hit;
    end

    // Shift in the new bit and saturate fill; non-overlap restarts history.
    always_comb begin
        hist_next = hist;
        fill_next = fill;
        if (x_valid) begin
            hist_next = cand[LEN-2:0];
            fill_next = (fill == FULL) ? FULL : fill + 1'b1;
            if (OVERLAP == 0 && hit) begin
                hist_next = '0;
                fill_next = '0;
            end
        end
    end

    // History and fill registers, cleared immediately on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist <= '0;
            fill <= '0;
        end else begin
            hist <= hist_next;
            fill <= fill_next;
        end
    end

    // Registered match: a one-cycle pulse following each hit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) z_reg <= 1'b0;
        else     z_reg <= hit;
    end

`ifdef SEQ_MATCH_CNT_EN
    // Saturating count of matches, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        match_cnt <= '0;
        else if (hit && match_cnt != '1) match_cnt <= match_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_seq_recognizer_param.sv
// Scoreboard bench for seq_recognizer_param across four configurations.
// Driver pushes hand-computed z/z_reg expectations; monitor checks on negedge.
module tb_seq_recognizer_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] xa  = '0;
    logic [3:0] va  = '0;
    logic [3:0] za;
    logic [3:0] zra;
`ifdef SEQ_MATCH_CNT_EN
    logic [7:0] cnt0, cnt1, cnt2;
    logic [1:0] cnt3;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        int   d;
        int   id;
        logic ez;
        logic ezr;
    } exp_t;

    exp_t sb[$];
    logic prev_ez [4];
    int   step_id = 0;

    always #5 clk = ~clk;

    seq_recognizer_param u0 (
        .clk(clk), .rst(rst), .x(xa[0]), .x_valid(va[0]),
        .z(za[0]), .z_reg(zra[0])
`ifdef SEQ_MATCH_CNT_EN
        , .match_cnt(cnt0)
`endif
    );

    seq_recognizer_param #(.OVERLAP(0)) u1 (
        .clk(clk), .rst(rst), .x(xa[1]), .x_valid(va[1]),
        .z(za[1]), .z_reg(zra[1])
`ifdef SEQ_MATCH_CNT_EN
        , .match_cnt(cnt1)
`endif
    );

    seq_recognizer_param #(.PATTERN(4'b0000)) u2 (
        .clk(clk), .rst(rst), .x(xa[2]), .x_valid(va[2]),
        .z(za[2]), .z_reg(zra[2])
`ifdef SEQ_MATCH_CNT_EN
        , .match_cnt(cnt2)
`endif
    );

    seq_recognizer_param #(.LEN(2), .PATTERN(2'b11), .CNT_W(2)) u3 (
        .clk(clk), .rst(rst), .x(xa[3]), .x_valid(va[3]),
        .z(za[3]), .z_reg(zra[3])
`ifdef SEQ_MATCH_CNT_EN
        , .match_cnt(cnt3)
`endif
    );

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask

    // Present one input vector to dut d for the next edge.
    task automatic step(input int d, input logic xv, input logic v,
                        input logic ez);
        exp_t e;
        @(posedge clk);
        #1;
        va = '0;
        xa = '0;
        va[d] = v;
        xa[d] = xv;
        step_id++;
        e.d   = d;
        e.id  = step_id;
        e.ez  = ez;
        e.ezr = prev_ez[d];
        prev_ez[d] = ez;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        va  = '0;
        rst = 1'b1;
        #3;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) prev_ez[i] = 1'b0;
    endtask

    task automatic run(input int d, input logic [15:0] bits,
                       input logic [15:0] vld, input logic [15:0] ez,
                       input int n);
        for (int i = n - 1; i >= 0; i--) step(d, bits[i], vld[i], ez[i]);
        step(d, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: compare whichever dut the oldest expectation targets.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (za[e.d] !== e.ez) begin
                errors++;
                $display("FAIL z dut%0d step%0d: got %b expected %b",
                         e.d, e.id, za[e.d], e.ez);
            end
            checks++;
            if (zra[e.d] !== e.ezr) begin
                errors++;
                $display("FAIL z_reg dut%0d step%0d: got %b expected %b",
                         e.d, e.id, zra[e.d], e.ezr);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 4; i++) prev_ez[i] = 1'b0;
        rst = 1'b1;
        #12;
        chk("reset_z", za, 0);
        chk("reset_z_reg", zra, 0);
`ifdef SEQ_MATCH_CNT_EN
        chk("reset_cnt0", cnt0, 0);
`endif
        rst = 1'b0;

        // Overlapping 1011 on 1,0,1,1,0,1,1: hits on bits 4 and 7.
        do_reset();
        run(0, 16'b1011011, 16'b1111111, 16'b0001001, 7);
        @(posedge clk);
        #1;
`ifdef SEQ_MATCH_CNT_EN
        chk("ovl_cnt", cnt0, 2);
`endif

        // Non-overlapping: second match needs four fresh bits.
        do_reset();
        run(1, 16'b1011011, 16'b1111111, 16'b0001000, 7);
        @(posedge clk);
        #1;
`ifdef SEQ_MATCH_CNT_EN
        chk("novl_cnt", cnt1, 1);
`endif

        // Warm-up: zero-filled history must not match early.
        do_reset();
        run(2, 16'b0000, 16'b1111, 16'b0001, 4);
        @(posedge clk);
        #1;
`ifdef SEQ_MATCH_CNT_EN
        chk("warm_cnt", cnt2, 1);
`endif

        // Gaps: 1,0, three idle cycles, 1,1.
        do_reset();
        run(0, 16'b1000011, 16'b1100011, 16'b0000001, 7);
        @(posedge clk);
        #1;
`ifdef SEQ_MATCH_CNT_EN
        chk("gap_cnt", cnt0, 1);
`endif

        // Reset mid-stream clears z_reg, counter and z at once.
        do_reset();
        run(0, 16'b1011, 16'b1111, 16'b0001, 4);
        do_reset();
        step(0, 1'b1, 1'b1, 1'b0);
        step(0, 1'b0, 1'b1, 1'b0);
        step(0, 1'b1, 1'b1, 1'b0);
        step(0, 1'b1, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        xa[0] = 1'b1;
        va[0] = 1'b1;
        #1;
        chk("pre_rst_z_reg", zra[0], 1);
`ifdef SEQ_MATCH_CNT_EN
        chk("pre_rst_cnt", cnt0, 1);
`endif
        rst = 1'b1;
        #1;
        chk("rst_z_reg", zra[0], 0);
        chk("rst_z", za[0], 0);
`ifdef SEQ_MATCH_CNT_EN
        chk("rst_cnt", cnt0, 0);
`endif
        va = '0;
        #1;
        rst = 1'b0;
        prev_ez[0] = 1'b0;
        step(0, 1'b1, 1'b1, 1'b0);
        step(0, 1'b0, 1'b1, 1'b0);
        step(0, 1'b1, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        va = '0;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        prev_ez[0] = 1'b0;
        step(0, 1'b1, 1'b1, 1'b0);
        step(0, 1'b0, 1'b0, 1'b0);

        // LEN=2 pattern 11: eight 1s give seven back-to-back hits.
        do_reset();
        run(3, 16'b11111111, 16'b11111111, 16'b01111111, 8);
        @(posedge clk);
        #1;
`ifdef SEQ_MATCH_CNT_EN
        chk("sat_cnt", cnt3, 3);
`endif

        repeat (3) @(posedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
